// File: rtl/itr_prio_primitives.sv
// Interrupt-priority datapath primitives: ITR/MASK registers, 4:2 priority
// encoder and 4:1 ISR address mux, plus the top that chains them together.

module ld_st_reg_4bit (
  input  logic       clk,
  input  logic       clr,
  input  logic       set,
  input  logic [3:0] in,
  output logic [3:0] out
);
  logic [3:0] r_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      r_q <= 4'b0000;
    else if (set)
      r_q <= in;
  end

  assign out = r_q;
endmodule

module pri_encoder_4_2 (
  input  logic [3:0] in,
  input  logic       enab,
  output logic [1:0] out,
  output logic       valid
);
  // Bit 0 wins; a disabled or empty request vector reports index 0.
  always_comb begin
    out   = 2'b00;
    valid = 1'b0;
    if (enab) begin
      valid = |in;
      if (in[0])      out = 2'd0;
      else if (in[1]) out = 2'd1;
      else if (in[2]) out = 2'd2;
      else if (in[3]) out = 2'd3;
    end
  end
endmodule

module mux_4_1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);
  always_comb begin
    case (sel)
      2'd0:    out = i1;
      2'd1:    out = i2;
      2'd2:    out = i3;
      2'd3:    out = i4;
      default: out = {WIDTH{1'bx}};
    endcase
  end
endmodule

module itr_prio_primitives (
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic       i_itr_set,
  input  logic [3:0] i_itr,
  input  logic       i_mask_set,
  input  logic [3:0] i_mask,
  input  logic       i_enab,
  input  logic       i_int_en,
  input  logic [7:0] i_isr1,
  input  logic [7:0] i_isr2,
  input  logic [7:0] i_isr3,
  input  logic [7:0] i_isr4,
  output logic [3:0] o_itr,
  output logic [3:0] o_mask,
  output logic [3:0] o_req,
  output logic [1:0] o_sel,
  output logic       o_valid,
  output logic       o_pending,
  output logic [7:0] o_addr
);
  logic [3:0] w_itr;
  logic [3:0] w_mask;
  logic [3:0] w_req;
  logic [1:0] w_sel;
  logic       w_valid;
  logic [7:0] w_addr;

  ld_st_reg_4bit u_itr_reg (
    .clk (i_clk),
    .clr (i_clr),
    .set (i_itr_set),
    .in  (i_itr),
    .out (w_itr)
  );

  ld_st_reg_4bit u_mask_reg (
    .clk (i_clk),
    .clr (i_clr),
    .set (i_mask_set),
    .in  (i_mask),
    .out (w_mask)
  );

  assign w_req = w_itr & w_mask;

  pri_encoder_4_2 u_enc (
    .in    (w_req),
    .enab  (i_enab),
    .out   (w_sel),
    .valid (w_valid)
  );

  mux_4_1 #(.WIDTH(8)) u_mux (
    .i1  (i_isr1),
    .i2  (i_isr2),
    .i3  (i_isr3),
    .i4  (i_isr4),
    .sel (w_sel),
    .out (w_addr)
  );

  assign o_itr     = w_itr;
  assign o_mask    = w_mask;
  assign o_req     = w_req;
  assign o_sel     = w_sel;
  assign o_valid   = w_valid;
  assign o_pending = w_valid & i_int_en;
  assign o_addr    = w_addr;
endmodule

// File: tb/tb_itr_prio_primitives.sv
// Bench for itr_prio_primitives: reference model plus directed literal checks.

module tb_itr_prio_primitives;
  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       itr_set = 1'b0;
  logic [3:0] itr_in = 4'h0;
  logic       mask_set = 1'b0;
  logic [3:0] mask_in = 4'h0;
  logic       enab = 1'b1;
  logic       int_en = 1'b1;
  logic [7:0] isr1 = 8'h96, isr2 = 8'hD7, isr3 = 8'hE6, isr4 = 8'h56;
  logic [3:0] o_itr, o_mask, o_req;
  logic [1:0] o_sel;
  logic       o_valid, o_pending;
  logic [7:0] o_addr;

  int n_checks = 0;
  int n_pass   = 0;
  bit run_cmp  = 1'b0;

  logic [3:0] m_itr = 4'h0;
  logic [3:0] m_mask = 4'h0;

  itr_prio_primitives dut (
    .i_clk(clk), .i_clr(clr), .i_itr_set(itr_set), .i_itr(itr_in),
    .i_mask_set(mask_set), .i_mask(mask_in), .i_enab(enab), .i_int_en(int_en),
    .i_isr1(isr1), .i_isr2(isr2), .i_isr3(isr3), .i_isr4(isr4),
    .o_itr(o_itr), .o_mask(o_mask), .o_req(o_req), .o_sel(o_sel),
    .o_valid(o_valid), .o_pending(o_pending), .o_addr(o_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Register model: a load happens on an edge only when not cleared.
  always @(posedge clk) begin
    if (!clr && itr_set)  m_itr  <= itr_in;
    if (!clr && mask_set) m_mask <= mask_in;
  end

  function automatic logic [2:0] lowest_bit(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return 3'(i);
    return 3'd4;
  endfunction

  always @(negedge clk) begin
    if (run_cmp) begin
      logic [3:0] req;
      logic [2:0] idx;
      logic [1:0] sel;
      logic       vld;
      logic [7:0] addr [4];
      addr[0] = isr1; addr[1] = isr2; addr[2] = isr3; addr[3] = isr4;
      req = m_itr & m_mask;
      idx = lowest_bit(req);
      vld = enab && (idx != 3'd4);
      sel = vld ? idx[1:0] : 2'd0;
      check("itr",     {4'h0, o_itr},     {4'h0, m_itr});
      check("mask",    {4'h0, o_mask},    {4'h0, m_mask});
      check("req",     {4'h0, o_req},     {4'h0, req});
      check("sel",     {6'h0, o_sel},     {6'h0, sel});
      check("valid",   {7'h0, o_valid},   {7'h0, vld});
      check("pending", {7'h0, o_pending}, {7'h0, vld & int_en});
      check("addr",    o_addr,            addr[sel]);
    end
  end

  task automatic next_drive();
    @(negedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1;
    #2;
    check("reset_itr",  {4'h0, o_itr},  8'h00);
    check("reset_mask", {4'h0, o_mask}, 8'h00);
    check("reset_valid", {7'h0, o_valid}, 8'h00);
    #1 clr = 1'b0;
    run_cmp = 1'b1;

    // Async clear between edges with set held high.
    next_drive();
    itr_set = 1'b1; itr_in = 4'hA;
    @(posedge clk); #2;
    check("load_A", {4'h0, o_itr}, 8'h0A);
    clr = 1'b1; m_itr = 4'h0; m_mask = 4'h0;
    #1;
    check("async_clr", {4'h0, o_itr}, 8'h00);
    #1 clr = 1'b0;
    itr_set = 1'b0;

    // Load then hold for three edges.
    next_drive();
    itr_set = 1'b1; itr_in = 4'h5;
    next_drive();
    check("load_5", {4'h0, o_itr}, 8'h05);
    itr_set = 1'b0; itr_in = 4'hF;
    repeat (3) next_drive();
    check("hold_5", {4'h0, o_itr}, 8'h05);

    // Encoder sweep through an all-ones mask.
    mask_set = 1'b1; mask_in = 4'hF;
    next_drive();
    mask_set = 1'b0;
    itr_set = 1'b1;
    for (int v = 0; v < 16; v++) begin
      itr_in = 4'(v);
      next_drive();
      if (v == 6) begin
        check("enc_0110_out", {6'h0, o_sel}, 8'd1);
        check("enc_0110_vld", {7'h0, o_valid}, 8'd1);
      end
      if (v == 8) begin
        check("enc_1000_out", {6'h0, o_sel}, 8'd3);
        check("enc_1000_vld", {7'h0, o_valid}, 8'd1);
      end
      if (v == 0) begin
        check("enc_0000_out", {6'h0, o_sel}, 8'd0);
        check("enc_0000_vld", {7'h0, o_valid}, 8'd0);
      end
    end

    // Disabled encoder with every request set.
    itr_in = 4'hF;
    next_drive();
    enab = 1'b0;
    #1;
    check("dis_vld", {7'h0, o_valid}, 8'd0);
    check("dis_out", {6'h0, o_sel},   8'd0);
    next_drive();
    enab = 1'b1;

    // Mux select via single-bit requests.
    for (int s = 0; s < 4; s++) begin
      itr_in = 4'b0001 << s;
      next_drive();
      case (s)
        0: check("mux_sel0", o_addr, 8'h96);
        1: check("mux_sel1", o_addr, 8'hD7);
        2: check("mux_sel2", o_addr, 8'hE6);
        default: check("mux_sel3", o_addr, 8'h56);
      endcase
    end

    // Chain: ITR=1100, MASK=0100.
    itr_in = 4'b1100; mask_set = 1'b1; mask_in = 4'b0100;
    next_drive();
    check("chain_sel",  {6'h0, o_sel},   8'd2);
    check("chain_addr", o_addr,          8'hE6);
    check("chain_vld",  {7'h0, o_valid}, 8'd1);
    int_en = 1'b0;
    #1;
    check("chain_pend_off", {7'h0, o_pending}, 8'd0);
    mask_in = 4'b0000;
    next_drive();
    check("chain_mask0_vld", {7'h0, o_valid}, 8'd0);
    itr_set = 1'b0; mask_set = 1'b0; int_en = 1'b1;
    next_drive();

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
